// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU. Single-cycle add/sub/mul/shift; divide via a WIDTH-step restoring divider.
// Define ALU_REM_EN to enable opcode 6 (remainder); otherwise opcode 6 behaves as reserved.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opc,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             dbz
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [2:0] OPC_ADD = 3'd0;
  localparam logic [2:0] OPC_SUB = 3'd1;
  localparam logic [2:0] OPC_MUL = 3'd2;
  localparam logic [2:0] OPC_DIV = 3'd3;
  localparam logic [2:0] OPC_SL  = 3'd4;
  localparam logic [2:0] OPC_SR  = 3'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             zero_q, zero_d, mnov_q, mnov_d, isrem_q, isrem_d;

  logic [SHW-1:0]         shamt;
  logic [WIDTH:0]         sum_w, dif_w;
  logic [2*WIDTH-1:0]     ext_a, ext_b, prod_w;
  logic signed [WIDTH-1:0] sra_w;
  logic [WIDTH-1:0]       alu_res;
  logic                   alu_ovf;
  logic                   is_div;
  logic [WIDTH-1:0]       mag_a, mag_b;
  logic [WIDTH:0]         shift_w, trial_w;
  logic [WIDTH-1:0]       part_nx, quo_nx, q_fix, r_fix;

  assign shamt  = op_b[SHW-1:0];
  assign sum_w  = {1'b0, op_a} + {1'b0, op_b};
  assign dif_w  = {1'b0, op_a} - {1'b0, op_b};
  assign ext_a  = {{WIDTH{op_signed & op_a[WIDTH-1]}}, op_a};
  assign ext_b  = {{WIDTH{op_signed & op_b[WIDTH-1]}}, op_b};
  assign prod_w = ext_a * ext_b;
  assign sra_w  = $signed(op_a) >>> shamt;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (opc)
      OPC_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_ovf = op_signed ? ((op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_w[WIDTH-1] != op_a[WIDTH-1]))
                            : sum_w[WIDTH];
      end
      OPC_SUB: begin
        alu_res = dif_w[WIDTH-1:0];
        alu_ovf = op_signed ? ((op_a[WIDTH-1] != op_b[WIDTH-1]) && (dif_w[WIDTH-1] != op_a[WIDTH-1]))
                            : dif_w[WIDTH];
      end
      OPC_MUL: begin
        alu_res = prod_w[WIDTH-1:0];
        alu_ovf = prod_w[2*WIDTH-1:WIDTH] != {WIDTH{op_signed & prod_w[WIDTH-1]}};
      end
      OPC_SL:  alu_res = op_a << shamt;
      OPC_SR:  alu_res = op_signed ? $unsigned(sra_w) : (op_a >> shamt);
      default: ;
    endcase
  end

`ifdef ALU_REM_EN
  assign is_div = (opc == OPC_DIV) || (opc == 3'd6);
`else
  assign is_div = (opc == OPC_DIV);
`endif

  // The divider works on magnitudes; signs are re-applied on the final step.
  assign mag_a = (op_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b = (op_signed && op_b[WIDTH-1]) ? -op_b : op_b;

  assign shift_w = {part_q, quo_q[WIDTH-1]};
  assign trial_w = shift_w - {1'b0, dvs_q};
  assign part_nx = trial_w[WIDTH] ? shift_w[WIDTH-1:0] : trial_w[WIDTH-1:0];
  assign quo_nx  = {quo_q[WIDTH-2:0], ~trial_w[WIDTH]};
  assign q_fix   = qneg_q ? -quo_nx : quo_nx;
  assign r_fix   = rneg_q ? -part_nx : part_nx;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    part_d   = part_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    a_d      = a_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    zero_d   = zero_q;
    mnov_d   = mnov_q;
    isrem_d  = isrem_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_div) begin
            state_d = BUSY;
            part_d  = '0;
            quo_d   = mag_a;
            dvs_d   = mag_b;
            a_d     = op_a;
            cnt_d   = CW'(WIDTH);
            qneg_d  = op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            rneg_d  = op_signed & op_a[WIDTH-1];
            zero_d  = (op_b == '0);
            mnov_d  = op_signed && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
            isrem_d = (opc != OPC_DIV);
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            ovf_d    = alu_ovf;
            dbz_d    = 1'b0;
          end
        end
      end
      BUSY: begin
        part_d = part_nx;
        quo_d  = quo_nx;
        cnt_d  = cnt_q - 1'b1;
        // Sign fix-up is folded into the last iteration so the result lands on the WIDTH-th step.
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          if (zero_q) begin
            result_d = isrem_q ? a_q : '1;
            ovf_d    = 1'b0;
            dbz_d    = 1'b1;
          end else begin
            result_d = isrem_q ? r_fix : q_fix;
            ovf_d    = mnov_q & ~isrem_q;
            dbz_d    = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      part_q   <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      zero_q   <= 1'b0;
      mnov_q   <= 1'b0;
      isrem_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      part_q   <= part_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      a_q      <= a_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      zero_q   <= zero_d;
      mnov_q   <= mnov_d;
      isrem_q  <= isrem_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;
endmodule
